// File: rtl/thermocouple_scanner.sv
// Round-robin scanner for several MAX31855-style converters behind one SPI master.
// Holds per-channel temperature, junction, fault, timeout and valid state, and pulses a strobe after each capture.
module thermocouple_scanner #(
    parameter int NCH           = 4,
    parameter int CLK_FREQ      = 48000,
    parameter int STARTUP_SEC   = 3,
    parameter int GAP_CYC       = 48000,
    parameter int BUSY_TIMEOUT  = 1024,
    parameter int HOLD_ON_FAULT = 1,
    parameter int CBITS         = 18,
    parameter int CHW           = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    ch_enable,
    input  logic              spi_not_busy,
    input  logic [31:0]       spi_rx_data,
    output logic              spi_ena,
    output logic [CHW-1:0]    spi_cs_sel,
    output logic [NCH*14-1:0] tc_temp_data,
    output logic [NCH*12-1:0] junction_temp_data,
    output logic [NCH*4-1:0]  fault_bits,
    output logic [NCH-1:0]    timeout_flags,
    output logic [NCH-1:0]    data_valid,
    output logic              sample_strobe,
    output logic [CHW-1:0]    sample_ch
);

    localparam int STARTUP_CYC = CLK_FREQ * STARTUP_SEC;
    localparam logic [CBITS-1:0] STARTUP_LAST = CBITS'(STARTUP_CYC - 1);
    localparam logic [CBITS-1:0] GAP_LAST     = CBITS'(GAP_CYC - 1);
    localparam logic [CBITS-1:0] BUSY_LAST    = CBITS'(BUSY_TIMEOUT - 1);

    typedef enum logic [2:0] {
        ST_STARTUP,
        ST_SELECT,
        ST_START,
        ST_WAIT,
        ST_CAPTURE,
        ST_GAP
    } state_t;

    state_t              state_q;
    logic [CBITS-1:0]    cnt_q;
    logic [CHW-1:0]      cur_q;
    logic [CHW-1:0]      cs_sel_q;
    logic                spi_ena_q;
    logic [NCH*14-1:0]   tc_q;
    logic [NCH*12-1:0]   jt_q;
    logic [NCH*4-1:0]    fault_q;
    logic [NCH-1:0]      timeout_q;
    logic [NCH-1:0]      valid_q;
    logic                strobe_q;
    logic [CHW-1:0]      sample_ch_q;

    logic                sel_found_d;
    logic [CHW-1:0]      sel_ch_d;
    logic                expired_d;

    // Walk offsets from far to near so the nearest enabled channel after cur_q wins.
    always_comb begin
        sel_found_d = 1'b0;
        sel_ch_d    = cur_q;
        for (int k = NCH; k >= 1; k--) begin
            if (ch_enable[CHW'((int'(cur_q) + k) % NCH)]) begin
                sel_found_d = 1'b1;
                sel_ch_d    = CHW'((int'(cur_q) + k) % NCH);
            end
        end
    end

    assign expired_d = (((state_q == ST_START) && spi_not_busy) ||
                        ((state_q == ST_WAIT) && !spi_not_busy)) && (cnt_q == BUSY_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_STARTUP;
            cnt_q       <= '0;
            cur_q       <= CHW'(NCH - 1);
            cs_sel_q    <= '0;
            spi_ena_q   <= 1'b0;
            tc_q        <= '0;
            jt_q        <= '0;
            fault_q     <= '0;
            timeout_q   <= '0;
            valid_q     <= '0;
            strobe_q    <= 1'b0;
            sample_ch_q <= '0;
        end else begin
            strobe_q <= 1'b0;
            case (state_q)
                ST_STARTUP: begin
                    if (cnt_q == STARTUP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_SELECT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_SELECT: begin
                    cnt_q <= '0;
                    if (sel_found_d) begin
                        cur_q     <= sel_ch_d;
                        cs_sel_q  <= sel_ch_d;
                        spi_ena_q <= 1'b1;
                        state_q   <= ST_START;
                    end
                end
                ST_START, ST_WAIT: begin
                    if (expired_d) begin
                        // A stuck transfer marks the channel stale and skips straight to the gap.
                        spi_ena_q        <= 1'b0;
                        timeout_q[cur_q] <= 1'b1;
                        valid_q[cur_q]   <= 1'b0;
                        cnt_q            <= '0;
                        state_q          <= ST_GAP;
                    end else if (state_q == ST_START && !spi_not_busy) begin
                        spi_ena_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= ST_WAIT;
                    end else if (state_q == ST_WAIT && spi_not_busy) begin
                        state_q <= ST_CAPTURE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    fault_q[int'(cur_q)*4 +: 4] <= {spi_rx_data[16], spi_rx_data[2:0]};
                    if (!spi_rx_data[16] || HOLD_ON_FAULT == 0) begin
                        tc_q[int'(cur_q)*14 +: 14] <= spi_rx_data[31:18];
                        jt_q[int'(cur_q)*12 +: 12] <= spi_rx_data[15:4];
                    end
                    valid_q[cur_q] <= !spi_rx_data[16];
                    if (!spi_rx_data[16]) begin
                        timeout_q[cur_q] <= 1'b0;
                    end
                    strobe_q    <= 1'b1;
                    sample_ch_q <= cur_q;
                    cnt_q       <= '0;
                    state_q     <= ST_GAP;
                end
                ST_GAP: begin
                    if (cnt_q == GAP_LAST) begin
                        cnt_q   <= '0;
                        state_q <= ST_SELECT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    spi_ena_q <= 1'b0;
                    cnt_q     <= '0;
                    state_q   <= ST_SELECT;
                end
            endcase
        end
    end

    assign spi_ena            = spi_ena_q;
    assign spi_cs_sel         = cs_sel_q;
    assign tc_temp_data       = tc_q;
    assign junction_temp_data = jt_q;
    assign fault_bits         = fault_q;
    assign timeout_flags      = timeout_q;
    assign data_valid         = valid_q;
    assign sample_strobe      = strobe_q;
    assign sample_ch          = sample_ch_q;

endmodule

// File: tb/tb_thermocouple_scanner.sv
// Directed bench for a two-channel scanner: table of transactions plus hand-written reset sequences.
module tb_thermocouple_scanner;

    localparam int NCH          = 2;
    localparam int CLK_FREQ     = 10;
    localparam int STARTUP_SEC  = 3;
    localparam int GAP_CYC      = 10;
    localparam int BUSY_TIMEOUT = 8;
    localparam int STARTUP_CYC  = CLK_FREQ * STARTUP_SEC;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  ch_enable;
    logic        spi_not_busy;
    logic [31:0] spi_rx_data;
    logic        spi_ena;
    logic        spi_cs_sel;
    logic [27:0] tc_temp_data;
    logic [23:0] junction_temp_data;
    logic [7:0]  fault_bits;
    logic [1:0]  timeout_flags;
    logic [1:0]  data_valid;
    logic        sample_strobe;
    logic        sample_ch;

    thermocouple_scanner #(
        .NCH(NCH), .CLK_FREQ(CLK_FREQ), .STARTUP_SEC(STARTUP_SEC), .GAP_CYC(GAP_CYC),
        .BUSY_TIMEOUT(BUSY_TIMEOUT), .HOLD_ON_FAULT(1), .CBITS(18)
    ) dut (
        .clk(clk), .rst(rst), .ch_enable(ch_enable), .spi_not_busy(spi_not_busy),
        .spi_rx_data(spi_rx_data), .spi_ena(spi_ena), .spi_cs_sel(spi_cs_sel),
        .tc_temp_data(tc_temp_data), .junction_temp_data(junction_temp_data),
        .fault_bits(fault_bits), .timeout_flags(timeout_flags), .data_valid(data_valid),
        .sample_strobe(sample_strobe), .sample_ch(sample_ch)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int   strobe_cnt = 0;
    int   strobe_cyc = 0;
    logic last_sch   = 1'b0;
    always @(negedge clk) begin
        if (sample_strobe) begin
            strobe_cnt = strobe_cnt + 1;
            strobe_cyc = cyc;
            last_sch   = sample_ch;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total = total + 1;
        if (act !== exp) begin
            bad = bad + 1;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wait_ena(output int at, output bit ok);
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (spi_ena) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
        end
    endtask

    task automatic wait_timeout_flag(input logic ch, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (timeout_flags[ch]) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    // stall: 0 = normal read, 1 = busy never returns, 2 = busy never drops
    typedef struct {
        logic [1:0]  en;
        logic [31:0] rx;
        int          stall;
        logic        ch;
        logic [27:0] tc;
        logic [23:0] jt;
        logic [7:0]  fb;
        logic [1:0]  dv;
        logic [1:0]  tf;
    } vec_t;

    vec_t vt[9];

    initial begin
        int  rel;
        int  at;
        bit  ok;
        bit  prev_cap;
        int  s0;
        bit  ena_seen;

        vt[0] = '{2'b11, 32'h0190_1A00, 0, 1'b0, 28'h0000064, 24'h0001A0, 8'h00, 2'b01, 2'b00};
        vt[1] = '{2'b11, 32'h0001_0001, 0, 1'b1, 28'h0000064, 24'h0001A0, 8'h90, 2'b01, 2'b00};
        vt[2] = '{2'b10, 32'h0320_0640, 0, 1'b1, 28'h0320064, 24'h0641A0, 8'h00, 2'b11, 2'b00};
        vt[3] = '{2'b10, 32'hFFFC_FFF8, 0, 1'b1, 28'hFFFC064, 24'hFFF1A0, 8'h00, 2'b11, 2'b00};
        vt[4] = '{2'b10, 32'h0000_0000, 1, 1'b1, 28'hFFFC064, 24'hFFF1A0, 8'h00, 2'b01, 2'b10};
        vt[5] = '{2'b11, 32'h0004_0016, 0, 1'b0, 28'hFFFC001, 24'hFFF001, 8'h06, 2'b01, 2'b10};
        vt[6] = '{2'b11, 32'h0190_1A00, 0, 1'b1, 28'h0190001, 24'h1A0001, 8'h06, 2'b11, 2'b00};
        vt[7] = '{2'b11, 32'h1235_0005, 0, 1'b0, 28'h0190001, 24'h1A0001, 8'h0D, 2'b10, 2'b00};
        vt[8] = '{2'b11, 32'h0000_0000, 2, 1'b1, 28'h0190001, 24'h1A0001, 8'h0D, 2'b00, 2'b10};

        rst          = 1'b1;
        ch_enable    = 2'b11;
        spi_not_busy = 1'b1;
        spi_rx_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_tc", {4'h0, tc_temp_data}, 32'h0);
        check("rst_jt", {8'h0, junction_temp_data}, 32'h0);
        check("rst_misc", {16'h0, spi_ena, spi_cs_sel, fault_bits, timeout_flags, data_valid,
                           sample_strobe, sample_ch}, 32'h0);
        rst = 1'b0;
        rel = cyc;
        prev_cap = 1'b0;

        for (int i = 0; i < 9; i++) begin
            s0 = strobe_cnt;
            ch_enable = vt[i].en;
            wait_ena(at, ok);
            check("ena_seen", {31'h0, ok}, 32'h1);
            if (!ok) continue;
            if (i == 0)
                check("startup_len", at - rel, STARTUP_CYC + 1);
            else if (prev_cap)
                check("gap_len", at - strobe_cyc, GAP_CYC + 1);
            check("cs_sel", {31'h0, spi_cs_sel}, {31'h0, vt[i].ch});

            if (vt[i].stall == 2) begin
                wait_timeout_flag(vt[i].ch, ok);
                check("start_timeout", {31'h0, ok}, 32'h1);
                check("ena_off_to", {31'h0, spi_ena}, 32'h0);
                repeat (3) @(negedge clk);
            end else begin
                repeat (2) @(negedge clk);
                spi_not_busy = 1'b0;
                @(negedge clk);
                check("ena_drop", {31'h0, spi_ena}, 32'h0);
                if (vt[i].stall == 1) begin
                    wait_timeout_flag(vt[i].ch, ok);
                    check("wait_timeout", {31'h0, ok}, 32'h1);
                    check("ena_off_to", {31'h0, spi_ena}, 32'h0);
                    spi_not_busy = 1'b1;
                    repeat (3) @(negedge clk);
                end else begin
                    repeat (4) @(negedge clk);
                    spi_rx_data  = vt[i].rx;
                    spi_not_busy = 1'b1;
                    for (int w = 0; w < 10; w++) begin
                        @(negedge clk);
                        if (strobe_cnt != s0) break;
                    end
                    repeat (3) @(negedge clk);
                    check("sample_ch", {31'h0, last_sch}, {31'h0, vt[i].ch});
                end
            end

            check("strobes", strobe_cnt - s0, (vt[i].stall == 0) ? 1 : 0);
            check("tc", {4'h0, tc_temp_data}, {4'h0, vt[i].tc});
            check("jt", {8'h0, junction_temp_data}, {8'h0, vt[i].jt});
            check("fault", {24'h0, fault_bits}, {24'h0, vt[i].fb});
            check("valid", {30'h0, data_valid}, {30'h0, vt[i].dv});
            check("tflags", {30'h0, timeout_flags}, {30'h0, vt[i].tf});
            $display("vec %0d ch=%0d stall=%0d tc=%h jt=%h fb=%h dv=%b tf=%b",
                     i, spi_cs_sel, vt[i].stall, tc_temp_data, junction_temp_data,
                     fault_bits, data_valid, timeout_flags);
            prev_cap = (vt[i].stall == 0);
        end

        // Reset in the middle of WAIT_DONE restarts the whole scan.
        ch_enable = 2'b11;
        wait_ena(at, ok);
        check("mid_ena_seen", {31'h0, ok}, 32'h1);
        repeat (2) @(negedge clk);
        spi_not_busy = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        spi_not_busy = 1'b1;
        rel = cyc;
        check("mid_rst_tc", {4'h0, tc_temp_data}, 32'h0);
        check("mid_rst_jt", {8'h0, junction_temp_data}, 32'h0);
        check("mid_rst_misc", {16'h0, spi_ena, spi_cs_sel, fault_bits, timeout_flags, data_valid,
                               sample_strobe, sample_ch}, 32'h0);
        wait_ena(at, ok);
        check("restart_seen", {31'h0, ok}, 32'h1);
        check("restart_len", at - rel, STARTUP_CYC + 1);
        check("restart_cs", {31'h0, spi_cs_sel}, 32'h0);
        $display("reset mid-transfer: restart after %0d cycles", at - rel);

        // With nothing enabled the scanner must never request a transfer.
        ch_enable = 2'b00;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        ena_seen = 1'b0;
        for (int i = 0; i < STARTUP_CYC + 80; i++) begin
            @(negedge clk);
            if (spi_ena) ena_seen = 1'b1;
        end
        check("idle_no_ena", {31'h0, ena_seen}, 32'h0);
        $display("all channels disabled: spi_ena seen=%0d", ena_seen);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
